// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_pkg
// Purpose  : Shared FSM state type, register offsets and STATUS/CTRL bit map
//            for the memory-mapped UART transmitter.
// Revision : 1.0  initial release
// ============================================================================
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Register select values taken from A[3:2]
    localparam logic [1:0] c_REG_TXDATA = 2'd0;
    localparam logic [1:0] c_REG_STATUS = 2'd1;
    localparam logic [1:0] c_REG_CTRL   = 2'd2;

    localparam int c_STAT_BUSY      = 0;
    localparam int c_STAT_FULL      = 1;
    localparam int c_STAT_EMPTY     = 2;
    localparam int c_STAT_OVF       = 3;
    localparam int c_STAT_COUNT_LSB = 8;

    localparam int c_CTRL_IRQ_EN    = 0;
    localparam int c_CTRL_ODD       = 1;

endpackage
`default_nettype wire

// File: rtl/uart_tx_mmio_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_mmio_if
// Purpose  : Data-memory style bus (WE/A/WD/RD) between core and peripheral.
// Revision : 1.0  initial release
// ============================================================================
interface uart_tx_mmio_if;
    logic        WE;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] RD;

    modport master (output WE, output A, output WD, input RD);
    modport slave  (input WE, input A, input WD, output RD);
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Synchronous FIFO with combinational head output; pushes while
//            full and pops while empty are ignored.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_din,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_dout,
    output logic                  o_full,
    output logic                  o_empty,
    output logic      [AW:0]      o_count
);
    localparam logic [AW-1:0] c_PTR_ONE = AW'(1);
    localparam logic [AW:0]   c_CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   c_CNT_MAX = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_CNT_MAX);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_mmio
// Purpose  : Memory-mapped 8N1 UART transmitter with TX FIFO, STATUS/CTRL
//            registers and drained interrupt. Define UART_TX_PARITY_EN to
//            add a parity bit (CTRL bit1 selects odd parity).
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_mmio
    import uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 8
) (
    input  wire logic      clk,
    input  wire logic      rst,
    uart_tx_mmio_if.slave  bus,
    output logic           tx,
    output logic           irq
);
    localparam int          c_BW          = $clog2(CLK_DIV);
    localparam int          c_AW          = $clog2(FIFO_DEPTH);
    localparam logic [c_BW-1:0] c_BAUD_RELOAD = c_BW'(CLK_DIV - 1);
    localparam logic [c_BW-1:0] c_BAUD_ONE    = c_BW'(1);

    uart_state_t     r_state;
    logic [c_BW-1:0] r_baud;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_tx;
    logic            r_ovf;
    logic            r_irq_en;
    logic            r_odd;

    logic            w_hit;
    logic [1:0]      w_sel;
    logic            w_wr;
    logic            w_push_req;
    logic            w_pop;
    logic            w_busy;
    logic            w_baud_done;
    logic [7:0]      w_dout;
    logic            w_full;
    logic            w_empty;
    logic [c_AW:0]   w_count;
    logic [31:0]     w_rd;
    logic            w_unused;

    assign w_hit       = (bus.A[31:4] == BASE_ADDR[31:4]);
    assign w_sel       = bus.A[3:2];
    assign w_wr        = w_hit & bus.WE;
    assign w_push_req  = w_wr & (w_sel == c_REG_TXDATA);
    assign w_busy      = (r_state != ST_IDLE);
    assign w_baud_done = (r_baud == '0);
    // Head byte leaves the FIFO when a frame starts from idle or chains on
    assign w_pop       = ~w_empty & ((r_state == ST_IDLE) |
                                     ((r_state == ST_STOP) & w_baud_done));
    assign w_unused    = &{1'b0, bus.A[1:0], bus.WD[31:8]};

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push_req),
        .i_din   (bus.WD[7:0]),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_rd = '0;
        if (w_hit) begin
            case (w_sel)
                c_REG_STATUS: begin
                    w_rd[c_STAT_BUSY]                   = w_busy;
                    w_rd[c_STAT_FULL]                   = w_full;
                    w_rd[c_STAT_EMPTY]                  = w_empty;
                    w_rd[c_STAT_OVF]                    = r_ovf;
                    w_rd[c_STAT_COUNT_LSB +: c_AW+1]    = w_count;
                end
                c_REG_CTRL: begin
                    w_rd[c_CTRL_IRQ_EN] = r_irq_en;
                    w_rd[c_CTRL_ODD]    = r_odd;
                end
                default: w_rd = '0;
            endcase
        end
    end

    assign bus.RD = w_rd;
    assign tx     = r_tx;
    assign irq    = r_irq_en & w_empty & ~w_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf    <= 1'b0;
            r_irq_en <= 1'b0;
            r_odd    <= 1'b0;
        end else begin
            if (w_push_req & w_full) begin
                r_ovf <= 1'b1;
            end else if (w_wr && (w_sel == c_REG_STATUS) && bus.WD[c_STAT_OVF]) begin
                r_ovf <= 1'b0;
            end
            if (w_wr && (w_sel == c_REG_CTRL)) begin
                r_irq_en <= bus.WD[c_CTRL_IRQ_EN];
`ifdef UART_TX_PARITY_EN
                r_odd    <= bus.WD[c_CTRL_ODD];
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state <= ST_START;
                        r_shift <= w_dout;
                        r_baud  <= c_BAUD_RELOAD;
                        r_tx    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_baud_done) begin
                        r_state   <= ST_DATA;
                        r_bit_idx <= '0;
                        r_baud    <= c_BAUD_RELOAD;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_baud <= r_baud - c_BAUD_ONE;
                    end
                end
                ST_DATA: begin
                    if (w_baud_done) begin
                        r_baud <= c_BAUD_RELOAD;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= ST_PARITY;
                            r_tx    <= (^r_shift) ^ r_odd;
`else
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_baud <= r_baud - c_BAUD_ONE;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_baud_done) begin
                        r_state <= ST_STOP;
                        r_baud  <= c_BAUD_RELOAD;
                        r_tx    <= 1'b1;
                    end else begin
                        r_baud <= r_baud - c_BAUD_ONE;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_baud_done) begin
                        // Chain straight into the next START so frames abut
                        if (!w_empty) begin
                            r_state <= ST_START;
                            r_shift <= w_dout;
                            r_baud  <= c_BAUD_RELOAD;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud - c_BAUD_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_mmio
// Purpose  : Scoreboard bench for uart_tx_mmio (CLK_DIV=4, FIFO_DEPTH=8).
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_mmio;
    logic clk = 1'b0;
    logic rst;
    logic tx;
    logic irq;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    uart_tx_mmio_if bus ();

    uart_tx_mmio #(
        .BASE_ADDR  (32'h0000_1000),
        .CLK_DIV    (4),
        .FIFO_DEPTH (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .tx  (tx),
        .irq (irq)
    );

    // kind: 0 = RD, 1 = irq, 2 = tx
    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } samp_t;

    // exp_start: cycle of first low tx sample, -2 = 40 cycles after previous frame
    typedef struct {
        logic [7:0] data;
        int         exp_start;
    } frame_t;

    samp_t  samp_q[$];
    frame_t frame_q[$];

    // Level sample monitor
    initial begin
        samp_t       s;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            #3;
            while (samp_q.size() > 0) begin
                s = samp_q.pop_front();
                case (s.kind)
                    0:       act = bus.RD;
                    1:       act = {31'b0, irq};
                    default: act = {31'b0, tx};
                endcase
                checks++;
                if (act !== s.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h (cycle %0d)", s.name, act, s.exp, cyc);
                end
            end
        end
    end

    // Serial frame monitor
    initial begin
        int         last_start;
        int         start;
        int         exp_start;
        logic       aborted;
        logic       bad_start;
        logic       stop_bit;
        logic [7:0] data;
        frame_t     f;
        last_start = -1000;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && tx === 1'b0) begin
                start     = cyc;
                aborted   = 1'b0;
                data      = '0;
                repeat (2) begin @(negedge clk); if (rst) aborted = 1'b1; end
                bad_start = (tx !== 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) begin @(negedge clk); if (rst) aborted = 1'b1; end
                    data[i] = tx;
                end
                repeat (4) begin @(negedge clk); if (rst) aborted = 1'b1; end
                stop_bit = tx;
                if (!aborted) begin
                    checks++;
                    if (frame_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_frame: got data %h at cycle %0d, expected no frame", data, start);
                    end else begin
                        f = frame_q.pop_front();
                        exp_start = (f.exp_start == -2) ? last_start + 40 : f.exp_start;
                        if (data !== f.data || stop_bit !== 1'b1 || bad_start ||
                            start != exp_start) begin
                            errors++;
                            $display("FAIL frame: got data %h start %0d stop %b startbit_bad %b, expected data %h start %0d stop 1",
                                     data, start, stop_bit, bad_start, f.data, exp_start);
                        end
                    end
                    last_start = start;
                end
            end
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.WE = 1'b1;
        bus.A  = a;
        bus.WD = d;
        @(negedge clk);
        bus.WE = 1'b0;
    endtask

    task automatic expect_rd(input string name, input logic [31:0] a, input logic [31:0] e);
        samp_t s;
        bus.WE = 1'b0;
        bus.A  = a;
        s.name = name; s.kind = 0; s.exp = e;
        samp_q.push_back(s);
        @(negedge clk);
    endtask

    task automatic expect_sig(input string name, input int kind, input logic e);
        samp_t s;
        s.name = name; s.kind = kind; s.exp = {31'b0, e};
        samp_q.push_back(s);
    endtask

    task automatic push_frame(input logic [7:0] d, input int st);
        frame_t f;
        f.data = d; f.exp_start = st;
        frame_q.push_back(f);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        bus.WE = 1'b0;
        bus.A  = '0;
        bus.WD = '0;
        rst    = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state and decode
        expect_sig("tx_reset", 2, 1'b1);
        expect_sig("irq_reset", 1, 1'b0);
        expect_rd("status_reset", 32'h1004, 32'h4);
        expect_rd("status_alias", 32'h1007, 32'h4);
        expect_rd("ctrl_reset", 32'h1008, 32'h0);
        expect_rd("txdata_read", 32'h1000, 32'h0);
        expect_rd("reserved_read", 32'h100C, 32'h0);
        expect_rd("miss_read", 32'h2004, 32'h0);
        bus_write(32'h2000, 32'h55);
        bus_write(32'h100C, 32'h77);
        repeat (5) @(negedge clk);

        // Single byte: start bit at N+1, busy drops at N+41
        bus_write(32'h1000, 32'hA5);
        n = cyc;
        push_frame(8'hA5, n + 1);
        expect_rd("status_after_push", 32'h1004, 32'h100);
        wait_until(n + 40);
        expect_rd("busy_before_end", 32'h1004, 32'h5);
        expect_rd("busy_dropped", 32'h1004, 32'h4);
        repeat (3) @(negedge clk);

        // Three bytes back to back
        bus_write(32'h1000, 32'h3C);
        n = cyc;
        push_frame(8'h3C, n + 1);
        bus_write(32'h1000, 32'h81);
        push_frame(8'h81, -2);
        bus_write(32'h1000, 32'h7E);
        push_frame(8'h7E, -2);
        expect_rd("count_2", 32'h1004, 32'h201);
        wait_until(n + 41);
        expect_rd("count_1", 32'h1004, 32'h101);
        wait_until(n + 81);
        expect_rd("count_0_busy", 32'h1004, 32'h5);
        wait_until(n + 121);
        expect_rd("b2b_idle", 32'h1004, 32'h4);
        repeat (3) @(negedge clk);

        // Overflow: 9 accepted, 10th dropped
        n = 0;
        for (int i = 0; i < 10; i++) begin
            bus_write(32'h1000, 32'h10 + i);
            if (i == 0) begin
                n = cyc;
                push_frame(8'h10, n + 1);
            end else if (i < 9) begin
                push_frame(8'h10 + 8'(i), -2);
            end
        end
        expect_rd("ovf_set", 32'h1004, 32'h80B);
        bus_write(32'h1004, 32'h8);
        expect_rd("ovf_clear", 32'h1004, 32'h803);
        wait_until(n + 366);
        expect_rd("ovf_drained", 32'h1004, 32'h4);

        // Interrupt
        bus_write(32'h1008, 32'h1);
        expect_sig("irq_idle", 1, 1'b1);
        expect_rd("ctrl_readback", 32'h1008, 32'h1);
        bus_write(32'h1000, 32'h5A);
        n = cyc;
        push_frame(8'h5A, n + 1);
        expect_sig("irq_pending", 1, 1'b0);
        wait_until(n + 40);
        expect_sig("irq_busy", 1, 1'b0);
        @(negedge clk);
        expect_sig("irq_done", 1, 1'b1);
        @(negedge clk);
        bus_write(32'h1008, 32'h0);
        expect_sig("irq_disabled", 1, 1'b0);
        repeat (3) @(negedge clk);

        // Reset mid-DATA discards the frame and FIFO contents
        bus_write(32'h1000, 32'h00);
        n = cyc;
        bus_write(32'h1000, 32'hFF);
        wait_until(n + 12);
        expect_sig("tx_data_low", 2, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        expect_sig("tx_async_reset", 2, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        expect_rd("status_after_rst", 32'h1004, 32'h4);
        expect_sig("irq_after_rst", 1, 1'b0);
        repeat (150) @(negedge clk);
        expect_sig("tx_idle_after_rst", 2, 1'b1);
        @(negedge clk);
        @(negedge clk);

        checks++;
        if (frame_q.size() != 0) begin
            errors++;
            $display("FAIL frames_missing: got %0d frames outstanding, expected 0", frame_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
